// File: rtl/dcache_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dcache_write_buffer
// Purpose  : Posted-write line buffer between the data cache and Data_Memory.
//            Write-backs are acked at once and drained in the background.
//            Reads are forwarded from buffered lines or go to memory after
//            any in-flight drain completes.
// Revision : 1.0  initial release
// ============================================================================
module dcache_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   up_enable_i,
  input  logic                   up_write_i,
  input  logic [ADDR_W-1:0]      up_addr_i,
  input  logic [DATA_W-1:0]      up_data_i,
  output logic                   up_ack_o,
  output logic [DATA_W-1:0]      up_data_o,
  output logic                   mem_enable_o,
  output logic                   mem_write_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic [DATA_W-1:0]      mem_data_o,
  input  logic [DATA_W-1:0]      mem_data_i,
  input  logic                   mem_ack_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = ADDR_W - 5;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM_WR = 2'd1,
    MEM_RD = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] line_mem [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              rd_pend, rd_pend_nxt;
  logic [TAG_W-1:0]  rd_tag;

  logic [TAG_W-1:0]  req_tag;
  logic              drain_busy;
  logic              wr_hit, rd_hit;
  logic [PTR_W-1:0]  wr_idx, rd_idx, scan_idx;
  logic              req_ok, do_coal, do_push, do_rdhit, do_rdmiss;
  logic              do_pop, rd_done, rd_go;
  logic [TAG_W-1:0]  rd_tag_sel;
  logic              start_wr, start_rd;
  logic [DATA_W-1:0] head_line;
  logic              unused_offset;

  // Byte offset within a line plays no part in tag matching.
  assign unused_offset = ^up_addr_i[4:0];

  assign req_tag    = up_addr_i[ADDR_W-1:5];
  assign drain_busy = (state == MEM_WR);
  assign count_o    = count;

  // Tag search from oldest to youngest so the last hit is the youngest match.
  // Reads may hit the in-flight head; writes must not modify it.
  always_comb begin
    wr_hit   = 1'b0;
    rd_hit   = 1'b0;
    wr_idx   = '0;
    rd_idx   = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (tag_mem[scan_idx] == req_tag)) begin
        rd_hit = 1'b1;
        rd_idx = scan_idx;
        if (!(drain_busy && (k == 0))) begin
          wr_hit = 1'b1;
          wr_idx = scan_idx;
        end
      end
    end
  end

  // A held request is looked at only once the previous ack has been seen by the cache.
  assign req_ok    = up_enable_i && !up_ack_o && (state != RESP) && !rd_pend;
  assign do_coal   = req_ok &&  up_write_i && wr_hit;
  assign do_push   = req_ok &&  up_write_i && !wr_hit && (count != FULL_CNT);
  assign do_rdhit  = req_ok && !up_write_i && rd_hit;
  assign do_rdmiss = req_ok && !up_write_i && !rd_hit;
  assign do_pop    = (state == MEM_WR) && mem_ack_i;
  assign rd_done   = (state == MEM_RD) && mem_ack_i;
  assign rd_go     = rd_pend || do_rdmiss;
  assign rd_tag_sel = rd_pend ? rd_tag : req_tag;

  assign start_wr = (state == IDLE) && (state_nxt == MEM_WR);
  assign start_rd = (state == IDLE) && (state_nxt == MEM_RD);

  // A coalescing write into the head in the same cycle the drain launches must
  // reach memory, so bypass the array.
  assign head_line = (do_coal && (wr_idx == head)) ? up_data_i : line_mem[head];

  // Memory-side state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Memory-side next state: a pending read miss wins over draining.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rd_go) begin
          state_nxt = MEM_RD;
        end else if (count != '0) begin
          state_nxt = MEM_WR;
        end
      end
      MEM_WR:  if (mem_ack_i) state_nxt = IDLE;
      MEM_RD:  if (mem_ack_i) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Occupancy and read-miss bookkeeping for the next cycle.
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - CNT_W'(1);
    end
    rd_pend_nxt = rd_pend;
    if (do_rdmiss) begin
      rd_pend_nxt = 1'b1;
    end else if (rd_done) begin
      rd_pend_nxt = 1'b0;
    end
  end

  // Entry storage; contents are meaningless outside the valid window so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      tag_mem[tail]  <= req_tag;
      line_mem[tail] <= up_data_i;
    end
    if (do_coal) begin
      line_mem[wr_idx] <= up_data_i;
    end
  end

  // FIFO pointers, count and the pending read-miss tag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      rd_pend <= 1'b0;
      rd_tag  <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_W'(1);
      if (do_pop)  head <= head + PTR_W'(1);
      count   <= count_nxt;
      rd_pend <= rd_pend_nxt;
      if (do_rdmiss) rd_tag <= req_tag;
    end
  end

  // Registered upstream and memory-side outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      up_ack_o     <= 1'b0;
      up_data_o    <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      empty_o      <= 1'b1;
    end else begin
      up_ack_o <= do_coal || do_push || do_rdhit || rd_done;
      if (do_rdhit) begin
        up_data_o <= line_mem[rd_idx];
      end else if (rd_done) begin
        up_data_o <= mem_data_i;
      end
      mem_enable_o <= (state_nxt == MEM_WR) || (state_nxt == MEM_RD);
      mem_write_o  <= (state_nxt == MEM_WR);
      if (start_wr) begin
        mem_addr_o <= {tag_mem[head], 5'b0};
        mem_data_o <= head_line;
      end else if (start_rd) begin
        mem_addr_o <= {rd_tag_sel, 5'b0};
      end
      empty_o <= (count_nxt == '0) && (state_nxt == IDLE) && !rd_pend_nxt;
    end
  end

endmodule
`default_nettype wire
